logic_vector_checker: RTL and testbench
=======================================

LOGIC_VECTOR_CHECKER -- requirements
Module: logic_vector_checker

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 2: cycles each vector is held before q is compared. Legal range 1..15; elaboration SHALL fail otherwise.
REQ-002 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  run request, sampled only in IDLE or DONE.
REQ-005 SHALL provide ports a, b, c, d  output  1 each  stimulus to the device under check; {a,b,c,d} = current vector, a = MSB.
REQ-006 SHALL provide port q  input  1  device response.
REQ-007 SHALL provide port busy  output  1  high in SETTLE or SAMPLE.
REQ-008 SHALL provide port done  output  1  high in DONE.
REQ-009 SHALL provide port pass  output  1  high in DONE when err_count == 0.
REQ-010 SHALL provide port err_count  output  5  mismatches in current/last run, 0..16.
REQ-011 SHALL provide ports first_fail_vec  output  4  and first_fail_valid  output  1, present only under LVC_ERR_LOG_EN.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-013 SHALL compute expected = (a & b) ^ (c & d) for the current vector.
REQ-014 IDLE: {a,b,c,d} = 0; start=1 → SETTLE, vector = 0, err_count = 0, settle counter = 0.
REQ-015 SETTLE: drive vector, count SETTLE_CYCLES cycles, then → SAMPLE.
REQ-016 SAMPLE: on the edge leaving SAMPLE, if q != expected, err_count increments by 1.
REQ-017 Leaving SAMPLE: vector < 15 → vector + 1, SETTLE, counter cleared; vector == 15 → DONE.
REQ-018 Each vector occupies SETTLE_CYCLES + 1 cycles; done SHALL rise exactly 16*(SETTLE_CYCLES+1) edges after the edge sampling start (48 for default).
REQ-019 DONE: done, pass, err_count and the last vector held stable until rst or start.
REQ-020 start in DONE SHALL behave as in IDLE (new run, err_count cleared, done low next cycle).
REQ-021 start while busy SHALL be ignored; the run continues unaltered.
REQ-022 err_count SHALL never wrap; maximum reachable value 16 fits 5 bits.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, vector 0, a=b=c=d=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, regardless of state.
REQ-024 rst SHALL take priority over start on the same edge.
REQ-025 A run aborted by reset SHALL NOT resume; a fresh start begins at vector 0.

Configuration
REQ-026 Macro LVC_ERR_LOG_EN defined: on the first mismatch of a run, first_fail_vec latches the vector and first_fail_valid sets; both hold until next start or rst.
REQ-027 LVC_ERR_LOG_EN undefined: first_fail_vec/first_fail_valid ports and their registers SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package lvc_pkg SHALL hold the state enum, VEC_W = 4, NUM_VEC = 16, CNT_W = 5.
REQ-029 Expected value SHALL come from sub-module lvc_golden (combinational reference model, inputs a,b,c,d, output exp_q).

Verification
REQ-030 Golden-correct device on q, SETTLE_CYCLES=2, start pulse → done at edge 48, pass=1, err_count=0, first_fail_valid=0.
REQ-031 q stuck at 0 → err_count=6 (vectors 3,7,11,12,13,14), pass=0, first_fail_vec=3.
REQ-032 q stuck at 1 → err_count=10, pass=0, first_fail_vec=0.
REQ-033 rst asserted while vector=5 in SETTLE → next cycle all outputs 0, IDLE; new start → full 48-cycle run, correct counts.
REQ-034 start pulses during busy ignored (done still at edge 48); start in DONE → done low next cycle, err_count=0, second run completes identically.
REQ-035 Build without LVC_ERR_LOG_EN, stuck-0 device → err_count=6, pass=0, first_fail ports absent.

Source files
------------

// File: rtl/lvc_pkg.sv
// Shared types and sizes for the logic vector checker.
package lvc_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lvc_golden.sv
// Combinational reference of the device under check: exp_q = (a & b) ^ (c & d).
module lvc_golden (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic exp_q
);

  assign exp_q = (a & b) ^ (c & d);

endmodule

// File: rtl/logic_vector_checker.sv
// Sweeps all 16 {a,b,c,d} vectors, compares q against lvc_golden and counts mismatches.
// Optional first-failure log is built only when LVC_ERR_LOG_EN is defined.
//
// state     | meaning
// ST_IDLE   | after reset, vector held at 0, waiting for start
// ST_SETTLE | driving current vector, settle timer running
// ST_SAMPLE | compare q with expected on the edge leaving this state
// ST_DONE   | sweep complete, results held until start or rst
module logic_vector_checker
  import lvc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count
`ifdef LVC_ERR_LOG_EN
  ,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  localparam int TMR_W = 4;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] vec, vec_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [CNT_W-1:0] err_nxt;
  logic             exp_q;
  logic             run_start;
  logic             mismatch;

  lvc_golden u_golden (
    .a     (vec[3]),
    .b     (vec[2]),
    .c     (vec[1]),
    .d     (vec[0]),
    .exp_q (exp_q)
  );

  assign run_start = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign mismatch  = (state == ST_SAMPLE) && (q != exp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      vec       <= '0;
      tmr       <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      tmr       <= tmr_nxt;
      err_count <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    tmr_nxt   = tmr;
    err_nxt   = err_count;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
          vec_nxt   = '0;
          tmr_nxt   = TMR_LOAD;
          err_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        if (tmr == '0) state_nxt = ST_SAMPLE;
        else           tmr_nxt   = tmr - 1'b1;
      end
      ST_SAMPLE: begin
        // Saturate rather than wrap; 16 is the most a single sweep can reach.
        if (mismatch && (err_count != CNT_W'(NUM_VEC))) err_nxt = err_count + 1'b1;
        if (vec == VEC_W'(NUM_VEC - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SETTLE;
          vec_nxt   = vec + 1'b1;
          tmr_nxt   = TMR_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign {a, b, c, d} = vec;
  assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);
  assign pass = (state == ST_DONE) && (err_count == '0);

`ifdef LVC_ERR_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (mismatch && !first_fail_valid) begin
      first_fail_vec   <= vec;
      first_fail_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_vector_checker.sv
// Randomized self-checking bench for logic_vector_checker; follows LVC_ERR_LOG_EN if defined.
module tb_logic_vector_checker;

  localparam int S = 2;
  localparam int RUN_EDGES = 16 * (S + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       a, b, c, d, q;
  logic       busy, done, pass;
  logic [4:0] err_count;
`ifdef LVC_ERR_LOG_EN
  logic [3:0] first_fail_vec;
  logic       first_fail_valid;
`endif

  logic [15:0] dev_tbl;
  logic [3:0]  vec_now;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign vec_now = {a, b, c, d};
  assign q = dev_tbl[vec_now];

  logic_vector_checker #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count)
`ifdef LVC_ERR_LOG_EN
    ,
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
`endif
  );

  function automatic logic [15:0] golden_table();
    logic [15:0] t;
    for (int v = 0; v < 16; v++) begin
      int av, bv, cv, dv;
      av = (v / 8) % 2; bv = (v / 4) % 2; cv = (v / 2) % 2; dv = v % 2;
      t[v] = 1'((av * bv + cv * dv) % 2);
    end
    return t;
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_check(input logic [15:0] tbl, input bit inject, input string name,
                           output int got_err, output int got_ff);
    int exp_err, exp_ff, k, bad_seq;
    logic [15:0] gold;
    gold = golden_table();
    exp_err = 0; exp_ff = -1; bad_seq = 0;
    for (int v = 0; v < 16; v++)
      if (tbl[v] != gold[v]) begin
        exp_err++;
        if (exp_ff < 0) exp_ff = v;
      end
    dev_tbl = tbl;
    start = 1'b1;
    edge_step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err_count !== 5'd0) begin
      errors++;
      $display("FAIL %s_start: busy=%b done=%b err=%0d expected busy=1 done=0 err=0",
               name, busy, done, err_count);
    end
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      if (vec_now !== 4'(k / (S + 1)) || busy !== 1'b1) bad_seq++;
      if (inject) start = ($urandom_range(0, 2) == 0);
      edge_step();
      k++;
    end
    start = 1'b0;
    checks++;
    if (bad_seq != 0) begin
      errors++;
      $display("FAIL %s_sequence: %0d bad cycles expected 0", name, bad_seq);
    end
    checks++;
    if (k != RUN_EDGES) begin
      errors++;
      $display("FAIL %s_latency: done after %0d edges expected %0d", name, k, RUN_EDGES);
    end
    checks++;
    if (err_count !== 5'(exp_err) || pass !== 1'(exp_err == 0) || busy !== 1'b0 || vec_now !== 4'd15) begin
      errors++;
      $display("FAIL %s_result: err=%0d pass=%b busy=%b vec=%0d expected err=%0d pass=%b busy=0 vec=15",
               name, err_count, pass, busy, vec_now, exp_err, exp_err == 0);
    end
`ifdef LVC_ERR_LOG_EN
    checks++;
    if (first_fail_valid !== 1'(exp_err != 0) || (exp_err != 0 && first_fail_vec !== 4'(exp_ff))) begin
      errors++;
      $display("FAIL %s_first_fail: valid=%b vec=%0d expected valid=%b vec=%0d",
               name, first_fail_valid, first_fail_vec, exp_err != 0, exp_ff);
    end
`endif
    repeat (3) edge_step();
    checks++;
    if (done !== 1'b1 || err_count !== 5'(exp_err) || vec_now !== 4'd15 || pass !== 1'(exp_err == 0)) begin
      errors++;
      $display("FAIL %s_hold: done=%b err=%0d vec=%0d expected done=1 err=%0d vec=15",
               name, done, err_count, vec_now, exp_err);
    end
    got_err = err_count;
`ifdef LVC_ERR_LOG_EN
    got_ff = first_fail_valid ? int'(first_fail_vec) : -1;
`else
    got_ff = exp_ff;
`endif
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({a, b, c, d, busy, done, pass} !== 7'd0 || err_count !== 5'd0) begin
      errors++;
      $display("FAIL %s: abcd=%b busy=%b done=%b pass=%b err=%0d expected all 0",
               name, vec_now, busy, done, pass, err_count);
    end
`ifdef LVC_ERR_LOG_EN
    checks++;
    if (first_fail_valid !== 1'b0 || first_fail_vec !== 4'd0) begin
      errors++;
      $display("FAIL %s_log: valid=%b vec=%0d expected 0 0", name, first_fail_valid, first_fail_vec);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    edge_step();
    edge_step();
    check_all_zero("reset_with_start");
    rst = 1'b0; start = 1'b0;
    repeat (3) edge_step();
    check_all_zero("idle_no_start");
  endtask

  task automatic test_golden();
    int e, f;
    run_check(golden_table(), 1'b0, "golden", e, f);
  endtask

  task automatic test_stuck();
    int e, f;
    run_check(16'h0000, 1'b0, "stuck0", e, f);
    checks++;
    if (e != 6 || f != 3) begin
      errors++;
      $display("FAIL stuck0_values: err=%0d first=%0d expected 6 and 3", e, f);
    end
    run_check(16'hFFFF, 1'b0, "stuck1", e, f);
    checks++;
    if (e != 10 || f != 0) begin
      errors++;
      $display("FAIL stuck1_values: err=%0d first=%0d expected 10 and 0", e, f);
    end
  endtask

  task automatic test_random();
    int e, f;
    for (int i = 0; i < 6; i++)
      run_check(16'($urandom()), 1'b0, $sformatf("rand%0d", i), e, f);
  endtask

  task automatic test_back_to_back();
    int e1, f1, e2, f2;
    logic [15:0] t;
    t = 16'($urandom());
    run_check(t, 1'b1, "b2b_first", e1, f1);
    run_check(t, 1'b1, "b2b_second", e2, f2);
    checks++;
    if (e1 != e2 || f1 != f2) begin
      errors++;
      $display("FAIL b2b_repeat: second err=%0d first=%0d expected %0d %0d", e2, f2, e1, f1);
    end
  endtask

  task automatic test_reset_mid_run();
    int k, e, f;
    dev_tbl = 16'h0000;
    start = 1'b1;
    edge_step();
    start = 1'b0;
    k = 0;
    while (vec_now !== 4'd5 && k < 100) begin
      edge_step();
      k++;
    end
    checks++;
    if (k != 5 * (S + 1) || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach_v5: edges=%0d busy=%b expected %0d 1", k, busy, 5 * (S + 1));
    end
    rst = 1'b1;
    edge_step();
    rst = 1'b0;
    check_all_zero("mid_run_reset");
    repeat (2) edge_step();
    check_all_zero("no_resume");
    run_check(16'h0000, 1'b0, "after_reset", e, f);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dev_tbl = 16'h0000;
    test_reset();
    test_golden();
    test_stuck();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
